// File: rtl/shape_editor.sv
// Frame-synchronous editor for up to MAXSHP tangram shapes: owns per-slot geometry and
// colour registers, applies button edits to the selected slot once per frame.
module shape_editor #(
  parameter int MAXSHP   = 4,
  parameter int INTW     = 12,
  parameter int PIXLW    = 12,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int MAX_TYPE = 3,
  parameter int MAX_SIZE = 255,
  parameter int DEF_SIZE = 10,
  parameter int ANG_STEP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame,
  input  logic [1:0]                  mode,
  input  logic                        l,
  input  logic                        r,
  input  logic                        u,
  input  logic                        d,
  input  logic                        l_once,
  input  logic                        r_once,
  input  logic                        c_once,
  input  logic [PIXLW-1:0]            pick_color,
  output logic [MAXSHP*INTW-1:0]      shp_x,
  output logic [MAXSHP*INTW-1:0]      shp_y,
  output logic [MAXSHP*INTW-1:0]      shp_size,
  output logic [MAXSHP*INTW-1:0]      shp_angle,
  output logic [MAXSHP*INTW-1:0]      shp_ty,
  output logic [MAXSHP*PIXLW-1:0]     shp_color,
  output logic [MAXSHP-1:0]           shp_en,
  output logic [$clog2(MAXSHP)-1:0]   sel,
  output logic [$clog2(MAXSHP+1)-1:0] count,
  output logic                        busy,
  output logic                        done
);
  localparam int SELW = $clog2(MAXSHP);
  localparam int CNTW = $clog2(MAXSHP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_APPLY = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [INTW-1:0] INIT_X = INTW'(SCREEN_W / 2);
  localparam logic [INTW-1:0] INIT_Y = INTW'(SCREEN_H / 2);
  localparam logic [INTW-1:0] MAX_X  = INTW'(SCREEN_W - 1);
  localparam logic [INTW-1:0] MAX_Y  = INTW'(SCREEN_H - 1);
  localparam logic [INTW-1:0] DEF_SZ = INTW'(DEF_SIZE);
  localparam logic [INTW-1:0] MAX_SZ = INTW'(MAX_SIZE);
  localparam logic [INTW-1:0] ONE    = INTW'(1);
  localparam logic [INTW-1:0] TY_MAX = INTW'(MAX_TYPE);

  // Angle math runs two bits wider so a step past +-180 never wraps before the fix-up.
  localparam logic signed [INTW+1:0] ANG_W    = (INTW+2)'(ANG_STEP);
  localparam logic signed [INTW+1:0] ANG_LO   = (INTW+2)'(-180);
  localparam logic signed [INTW+1:0] ANG_HI   = (INTW+2)'(179);
  localparam logic signed [INTW+1:0] ANG_FULL = (INTW+2)'(360);

  localparam logic [SELW-1:0]  LAST_IDX   = SELW'(MAXSHP - 1);
  localparam logic [SELW-1:0]  PROBE_LAST = SELW'(MAXSHP - 2);
  localparam logic [CNTW-1:0]  CNT_MAX    = CNTW'(MAXSHP);
  localparam logic [CNTW-1:0]  CNT_ONE    = CNTW'(1);
  localparam logic [PIXLW-1:0] WHITE      = '1;

  logic [2:0]      state_q, state_d;
  logic [SELW-1:0] idx_q, idx_d, probes_q, probes_d, sel_q, sel_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [MAXSHP-1:0] en_q, en_d;
  logic [INTW-1:0] x_q [MAXSHP];
  logic [INTW-1:0] x_d [MAXSHP];
  logic [INTW-1:0] y_q [MAXSHP];
  logic [INTW-1:0] y_d [MAXSHP];
  logic [INTW-1:0] size_q [MAXSHP];
  logic [INTW-1:0] size_d [MAXSHP];
  logic [INTW-1:0] ang_q [MAXSHP];
  logic [INTW-1:0] ang_d [MAXSHP];
  logic [INTW-1:0] ty_q [MAXSHP];
  logic [INTW-1:0] ty_d [MAXSHP];
  logic [PIXLW-1:0] color_q [MAXSHP];
  logic [PIXLW-1:0] color_d [MAXSHP];

  logic signed [INTW+1:0] angWide;
  logic [SELW-1:0]        freeSlot;

  function automatic logic [SELW-1:0] wrapInc(input logic [SELW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + SELW'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    probes_d = probes_q;
    sel_d    = sel_q;
    count_d  = count_q;
    en_d     = en_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    ang_d    = ang_q;
    ty_d     = ty_q;
    color_d  = color_q;
    angWide  = {{2{ang_q[sel_q][INTW-1]}}, ang_q[sel_q]};
    freeSlot = '0;
    for (int i = MAXSHP - 1; i >= 0; i--) begin
      if (!en_q[i]) freeSlot = SELW'(i);
    end

    case (state_q)
      S_IDLE: if (frame) state_d = S_APPLY;

      S_INIT: begin
        x_d[idx_q]     = INIT_X;
        y_d[idx_q]     = INIT_Y;
        size_d[idx_q]  = DEF_SZ;
        ang_d[idx_q]   = '0;
        ty_d[idx_q]    = '0;
        color_d[idx_q] = '0;
        en_d[idx_q]    = 1'b0;
        if (idx_q == LAST_IDX) begin
          en_d[0]    = 1'b1;
          color_d[0] = WHITE;
          sel_d      = '0;
          count_d    = CNT_ONE;
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + SELW'(1);
        end
      end

      S_APPLY: begin
        state_d = S_DONE;
        case (mode)
          2'd0: begin
            if (u) begin
              if (y_q[sel_q] != '0) y_d[sel_q] = y_q[sel_q] - ONE;
            end else if (d) begin
              if (y_q[sel_q] < MAX_Y) y_d[sel_q] = y_q[sel_q] + ONE;
            end
            if (l) begin
              if (x_q[sel_q] != '0) x_d[sel_q] = x_q[sel_q] - ONE;
            end else if (r) begin
              if (x_q[sel_q] < MAX_X) x_d[sel_q] = x_q[sel_q] + ONE;
            end
          end
          2'd1: begin
            if (l) begin
              angWide = angWide - ANG_W;
              if (angWide < ANG_LO) angWide = angWide + ANG_FULL;
            end else if (r) begin
              angWide = angWide + ANG_W;
              if (angWide > ANG_HI) angWide = angWide - ANG_FULL;
            end
            ang_d[sel_q] = angWide[INTW-1:0];
            if (u) begin
              if (size_q[sel_q] < MAX_SZ) size_d[sel_q] = size_q[sel_q] + ONE;
            end else if (d) begin
              if (size_q[sel_q] > ONE) size_d[sel_q] = size_q[sel_q] - ONE;
            end
            if (c_once) ty_d[sel_q] = (ty_q[sel_q] == TY_MAX) ? '0 : ty_q[sel_q] + ONE;
          end
          2'd2: begin
            // A request that cannot be honoured (add when full, remove the last slot) is a no-op.
            if (r_once) begin
              if (count_q < CNT_MAX) begin
                en_d[freeSlot]    = 1'b1;
                color_d[freeSlot] = WHITE;
                x_d[freeSlot]     = INIT_X;
                y_d[freeSlot]     = INIT_Y;
                size_d[freeSlot]  = DEF_SZ;
                ang_d[freeSlot]   = '0;
                ty_d[freeSlot]    = '0;
                sel_d             = freeSlot;
                count_d           = count_q + CNT_ONE;
              end
            end else if (l_once) begin
              if (count_q > CNT_ONE) begin
                en_d[sel_q]    = 1'b0;
                color_d[sel_q] = '0;
                count_d        = count_q - CNT_ONE;
                state_d        = S_SCAN;
              end
            end else if (c_once) begin
              state_d = S_SCAN;
            end
            idx_d    = wrapInc(sel_q);
            probes_d = '0;
          end
          default: if (c_once) color_d[sel_q] = pick_color;
        endcase
      end

      S_SCAN: begin
        if (en_q[idx_q]) begin
          sel_d   = idx_q;
          state_d = S_DONE;
        end else if (probes_q == PROBE_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d    = wrapInc(idx_q);
          probes_d = probes_q + SELW'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only control state is reset; INIT rewrites every slot before the slot data is trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      probes_q <= probes_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      en_q     <= en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      size_q   <= size_d;
      ang_q    <= ang_d;
      ty_q     <= ty_d;
      color_q  <= color_d;
    end
  end

  for (genvar g = 0; g < MAXSHP; g++) begin : gPack
    assign shp_x[g*INTW +: INTW]       = x_q[g];
    assign shp_y[g*INTW +: INTW]       = y_q[g];
    assign shp_size[g*INTW +: INTW]    = size_q[g];
    assign shp_angle[g*INTW +: INTW]   = ang_q[g];
    assign shp_ty[g*INTW +: INTW]      = ty_q[g];
    assign shp_color[g*PIXLW +: PIXLW] = en_q[g] ? color_q[g] : '0;
  end

  assign shp_en = en_q;
  assign sel    = sel_q;
  assign count  = count_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_shape_editor.sv
// Scoreboard bench for shape_editor: each frame pushes the reference model's expected
// shape table; a forked monitor pops and compares on every done pulse.
module tb_shape_editor;
  localparam int MAXSHP = 4;
  localparam int INTW   = 12;
  localparam int PIXLW  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame = 1'b0;
  logic [1:0] mode = 2'd0;
  logic lBtn = 1'b0, rBtn = 1'b0, uBtn = 1'b0, dBtn = 1'b0;
  logic lOnce = 1'b0, rOnce = 1'b0, cOnce = 1'b0;
  logic [PIXLW-1:0] pickColor = '0;

  logic [MAXSHP*INTW-1:0]  shpX, shpY, shpSize, shpAngle, shpTy;
  logic [MAXSHP*PIXLW-1:0] shpColor;
  logic [MAXSHP-1:0]       shpEn;
  logic [1:0]              sel;
  logic [2:0]              count;
  logic                    busy, done;

  shape_editor dut (
    .clk(clk), .rst(rst), .frame(frame), .mode(mode),
    .l(lBtn), .r(rBtn), .u(uBtn), .d(dBtn),
    .l_once(lOnce), .r_once(rOnce), .c_once(cOnce), .pick_color(pickColor),
    .shp_x(shpX), .shp_y(shpY), .shp_size(shpSize), .shp_angle(shpAngle), .shp_ty(shpTy),
    .shp_color(shpColor), .shp_en(shpEn), .sel(sel), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MAXSHP*INTW-1:0]  x, y, sz, ang, ty;
    logic [MAXSHP*PIXLW-1:0] col;
    logic [MAXSHP-1:0]       en;
    logic [1:0]              sel;
    logic [2:0]              cnt;
  } expT;

  expT   expQ[$];
  string tagQ[$];
  int testCount = 0;
  int failCount = 0;

  // Reference model: plain integers per slot, angles held as signed degrees.
  int mx[MAXSHP], my[MAXSHP], msz[MAXSHP], mang[MAXSHP], mty[MAXSHP], mcol[MAXSHP];
  bit men[MAXSHP];
  int msel, mcnt;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void resetSlot(int i);
    mx[i] = 400; my[i] = 300; msz[i] = 10; mang[i] = 0; mty[i] = 0;
  endfunction

  function automatic void modelInit();
    for (int i = 0; i < MAXSHP; i++) begin
      resetSlot(i); mcol[i] = 0; men[i] = 0;
    end
    men[0] = 1; mcol[0] = 'hFFF; msel = 0; mcnt = 1;
  endfunction

  function automatic void modelScan();
    for (int p = 1; p < MAXSHP; p++) begin
      int j = (msel + p) % MAXSHP;
      if (men[j]) begin
        msel = j;
        return;
      end
    end
  endfunction

  function automatic void modelApply(int m, bit bl, bit br, bit bu, bit bd,
                                     bit lo, bit ro, bit co, int pick);
    int s = msel;
    case (m)
      0: begin
        if (bu) begin if (my[s] > 0) my[s]--; end
        else if (bd) begin if (my[s] < 599) my[s]++; end
        if (bl) begin if (mx[s] > 0) mx[s]--; end
        else if (br) begin if (mx[s] < 799) mx[s]++; end
      end
      1: begin
        if (bl) begin mang[s] -= 1; if (mang[s] < -180) mang[s] += 360; end
        else if (br) begin mang[s] += 1; if (mang[s] > 179) mang[s] -= 360; end
        if (bu) begin if (msz[s] < 255) msz[s]++; end
        else if (bd) begin if (msz[s] > 1) msz[s]--; end
        if (co) mty[s] = (mty[s] == 3) ? 0 : mty[s] + 1;
      end
      2: begin
        if (ro) begin
          if (mcnt < MAXSHP) begin
            int k = 0;
            while (men[k]) k++;
            men[k] = 1; mcol[k] = 'hFFF; resetSlot(k); msel = k; mcnt++;
          end
        end else if (lo) begin
          if (mcnt > 1) begin
            men[s] = 0; mcol[s] = 0; mcnt--; modelScan();
          end
        end else if (co) begin
          modelScan();
        end
      end
      default: if (co) mcol[s] = pick;
    endcase
  endfunction

  function automatic expT snapshot();
    expT e;
    for (int i = 0; i < MAXSHP; i++) begin
      e.x[i*INTW +: INTW]     = INTW'(mx[i]);
      e.y[i*INTW +: INTW]     = INTW'(my[i]);
      e.sz[i*INTW +: INTW]    = INTW'(msz[i]);
      e.ang[i*INTW +: INTW]   = INTW'(mang[i]);
      e.ty[i*INTW +: INTW]    = INTW'(mty[i]);
      e.col[i*PIXLW +: PIXLW] = men[i] ? PIXLW'(mcol[i]) : '0;
      e.en[i]                 = men[i];
    end
    e.sel = 2'(msel);
    e.cnt = 3'(mcnt);
    return e;
  endfunction

  function automatic void checkOutput();
    expT e;
    string t;
    if (expQ.size() == 0) begin
      testCount++; failCount++;
      $display("[TB] FAIL unexpectedDone: got done=1, expected no done pulse");
      return;
    end
    e = expQ.pop_front();
    t = tagQ.pop_front();
    check({t, ".en"},    shpEn,    e.en);
    check({t, ".sel"},   sel,      e.sel);
    check({t, ".count"}, count,    e.cnt);
    check({t, ".x"},     shpX,     e.x);
    check({t, ".y"},     shpY,     e.y);
    check({t, ".size"},  shpSize,  e.sz);
    check({t, ".angle"}, shpAngle, e.ang);
    check({t, ".ty"},    shpTy,    e.ty);
    check({t, ".color"}, shpColor, e.col);
  endfunction

  task automatic issueFrame(int m, bit bl, bit br, bit bu, bit bd,
                            bit lo, bit ro, bit co, logic [PIXLW-1:0] pick, string tag);
    mode = 2'(m); lBtn = bl; rBtn = br; uBtn = bu; dBtn = bd;
    lOnce = lo; rOnce = ro; cOnce = co; pickColor = pick;
    modelApply(m, bl, br, bu, bd, lo, ro, co, int'(pick));
    expQ.push_back(snapshot());
    tagQ.push_back(tag);
    frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
  endtask

  task automatic waitDone(string tag);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check({tag, ".doneSeen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
    lOnce = 1'b0; rOnce = 1'b0; cOnce = 1'b0;
  endtask

  task automatic applyStimulus(int m, bit bl, bit br, bit bu, bit bd,
                               bit lo, bit ro, bit co, logic [PIXLW-1:0] pick, string tag);
    issueFrame(m, bl, br, bu, bd, lo, ro, co, pick, tag);
    waitDone(tag);
  endtask

  task automatic applyReset(string tag);
    int busyCycles = 0;
    bit seen = 0;
    rst = 1'b1;
    expQ.delete(); tagQ.delete();
    modelInit();
    expQ.push_back(snapshot());
    tagQ.push_back(tag);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) seen = 1;
    end
    check({tag, ".busyCycles"}, 64'(busyCycles), 64'(MAXSHP + 1));
    @(negedge clk);
    check({tag, ".idleAfter"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && done === 1'b1) checkOutput();
      end
    join_none

    @(posedge clk); #1;
    applyReset("T1reset");

    // Walk slot 0 into the top-left corner, then hold there with all of l/r/u pressed.
    for (int n = 0; n < 402; n++) applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, '0, "T2clamp");
    for (int n = 0; n < 3; n++)   applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, '0, "T2right");

    for (int n = 0; n < 179; n++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, '0, "T3rotUp");
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, '0, "T3wrapNeg");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, "T3wrapPos");
    for (int n = 0; n < 10; n++)  applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, '0, "T3sizeFloor");
    for (int n = 0; n < 4; n++)   applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, '0, "T3type");

    applyStimulus(3, 0, 0, 0, 0, 0, 0, 1, 12'h5A3, "Tcolor");
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 12'h111, "TcolorNoPress");

    for (int n = 0; n < 4; n++) applyStimulus(2, 0, 0, 0, 0, 0, 1, 0, '0, "T4add");
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 1, '0, "T4selWrap");

    applyStimulus(2, 0, 0, 0, 0, 0, 0, 1, '0, "T5sel1");
    for (int n = 0; n < 4; n++) applyStimulus(2, 0, 0, 0, 0, 1, 0, 0, '0, "T5remove");

    // Only slot 0 is enabled now, so a select runs the full SCAN; a frame during it is dropped.
    issueFrame(2, 0, 0, 0, 0, 0, 0, 1, '0, "T6scanDrop");
    @(posedge clk); #1 frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
    waitDone("T6scanDrop");
    repeat (8) @(negedge clk);
    check("T6dropIdle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    issueFrame(2, 0, 0, 0, 0, 0, 0, 1, '0, "T6scanReset");
    @(posedge clk); #1;
    applyReset("T6rstInScan");

    rst = 1'b1; expQ.delete(); tagQ.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    applyReset("T6rstInInit");

    for (int n = 0; n < 400; n++) begin
      bit bl, br, bu, bd, lo, ro, co;
      int m, k;
      m  = $urandom_range(0, 3);
      bl = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      bu = 1'($urandom_range(0, 1)); bd = 1'($urandom_range(0, 1));
      lo = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
      co = 1'($urandom_range(0, 1));
      if (m == 2) begin
        k = $urandom_range(0, 3);
        ro = (k == 1); lo = (k == 2); co = (k == 3);
      end
      applyStimulus(m, bl, br, bu, bd, lo, ro, co, PIXLW'($urandom), $sformatf("R%0d", n));
    end

    repeat (5) @(negedge clk);
    check("endQueueEmpty", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
